// File: rtl/bju_pkg.sv
// bju_pkg: shared FSM/npc-select enums, opinfo bit indices and helpers for the branch/jump unit.
package bju_pkg;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_ACK = 1'b1
    } bju_state_e;

    typedef enum logic [1:0] {
        NPC_SEQ  = 2'd0,
        NPC_BR   = 2'd1,
        NPC_JALR = 2'd2,
        NPC_CSR  = 2'd3
    } npc_sel_e;

    localparam int OP_W      = 12;
    localparam int OP_ALU    = 0;
    localparam int OP_LUI    = 1;
    localparam int OP_AUIPC  = 2;
    localparam int OP_BRANCH = 3;
    localparam int OP_JAL    = 4;
    localparam int OP_JALR   = 5;
    localparam int OP_LOAD   = 6;
    localparam int OP_STORE  = 7;
    localparam int OP_MUL    = 8;
    localparam int OP_DIV    = 9;
    localparam int OP_CSR    = 10;
    localparam int OP_SYS    = 11;

    function automatic logic is_cf(input logic [OP_W-1:0] op);
        return op[OP_BRANCH] | op[OP_JAL] | op[OP_JALR] | op[OP_SYS];
    endfunction

endpackage

// File: rtl/bju_npc.sv
// bju_npc: combinational actual-next-PC computation and mispredict detection.
module bju_npc
    import bju_pkg::*;
(
    input  logic [31:0]     pc_i,
    input  logic [31:0]     pred_pc_i,
    input  logic [31:0]     imm_i,
    input  logic [31:0]     src1_i,
    input  logic [31:0]     csr_data_i,
    input  logic [OP_W-1:0] opinfo_i,
    input  logic            cnd_i,
    input  logic            ecall_i,
    input  logic            mret_i,
    output logic [31:0]     npc_o,
    output logic            mis_o
);

    npc_sel_e    sel;
    logic [31:0] jalr_sum;
    logic        unused_op;

    assign unused_op = ^{opinfo_i[OP_W-1:OP_JALR+1], opinfo_i[OP_BRANCH-1:0]};
    assign jalr_sum  = src1_i + imm_i;

    always_comb begin
        sel = (ecall_i | mret_i)                                ? NPC_CSR  :
              opinfo_i[OP_JALR]                                 ? NPC_JALR :
              (opinfo_i[OP_JAL] | (opinfo_i[OP_BRANCH] & cnd_i)) ? NPC_BR   :
                                                                  NPC_SEQ;
        npc_o = (sel == NPC_CSR)  ? csr_data_i :
                (sel == NPC_JALR) ? {jalr_sum[31:1], 1'b0} :
                (sel == NPC_BR)   ? pc_i + imm_i :
                                    pc_i + 32'd4;
        mis_o = npc_o != pred_pc_i;
    end

endmodule

// File: rtl/bju.sv
// bju: redirect FSM, fetch epoch and optional perf counters (YSYX_23060251_BJU_PERF_EN).
module bju
    import bju_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [31:0]       ex_pc_i,
    input  logic [31:0]       ex_pred_pc_i,
    input  logic [31:0]       ex_imm_i,
    input  logic [31:0]       ex_src1_i,
    input  logic [31:0]       ex_csr_data_i,
    input  logic [OP_W-1:0]   ex_opinfo_i,
    input  logic              ex_cnd_i,
    input  logic              ex_ecall_i,
    input  logic              ex_mret_i,
    input  logic              ex_epoch_i,
    output logic              redir_valid_o,
    input  logic              redir_ready_i,
    output logic [31:0]       redir_pc_o,
    output logic              flush_o,
    output logic              epoch_o
`ifdef YSYX_23060251_BJU_PERF_EN
   ,output logic [CNT_W-1:0]  perf_cf_cnt_o,
    output logic [CNT_W-1:0]  perf_mis_cnt_o
`endif
);

    localparam logic [0:0] IDLE     = ST_IDLE;
    localparam logic [0:0] WAIT_ACK = ST_WAIT_ACK;

    logic [0:0]  state_q, state_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        flush_q, flush_d;
    logic        epoch_q, epoch_d;
    logic [31:0] npc;
    logic        mis;
    logic        live;
    logic        redir;

    bju_npc u_npc (
        .pc_i       (ex_pc_i),
        .pred_pc_i  (ex_pred_pc_i),
        .imm_i      (ex_imm_i),
        .src1_i     (ex_src1_i),
        .csr_data_i (ex_csr_data_i),
        .opinfo_i   (ex_opinfo_i),
        .cnd_i      (ex_cnd_i),
        .ecall_i    (ex_ecall_i),
        .mret_i     (ex_mret_i),
        .npc_o      (npc),
        .mis_o      (mis)
    );

    assign ex_ready_o    = state_q == IDLE;
    assign redir_valid_o = state_q == WAIT_ACK;
    assign redir_pc_o    = redir_pc_q;
    assign flush_o       = flush_q;
    assign epoch_o       = epoch_q;

    // Stale-epoch instructions are wrong-path leftovers: accepted but otherwise ignored.
    assign live  = ex_valid_i & ex_ready_o & (ex_epoch_i == epoch_q);
    assign redir = live & mis;

    always_comb begin
        state_d    = (state_q == IDLE) ? (redir ? WAIT_ACK : IDLE)
                                       : (redir_ready_i ? IDLE : WAIT_ACK);
        redir_pc_d = redir ? npc : redir_pc_q;
        flush_d    = redir;
        epoch_d    = epoch_q ^ redir;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            redir_pc_q <= '0;
            flush_q    <= 1'b0;
            epoch_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            redir_pc_q <= redir_pc_d;
            flush_q    <= flush_d;
            epoch_q    <= epoch_d;
        end
    end

`ifdef YSYX_23060251_BJU_PERF_EN
    logic [CNT_W-1:0] cf_cnt_q, cf_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

    always_comb begin
        cf_cnt_d  = (live & is_cf(ex_opinfo_i)) ? cf_cnt_q + CNT_W'(1) : cf_cnt_q;
        mis_cnt_d = redir ? mis_cnt_q + CNT_W'(1) : mis_cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cf_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            cf_cnt_q  <= cf_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign perf_cf_cnt_o  = cf_cnt_q;
    assign perf_mis_cnt_o = mis_cnt_q;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: doc/bju.md
BJU -- requirements
Module: bju

Interface
REQ-001: Parameter CNT_W, default 32, width of the performance counters.
REQ-002: clk_i  input  1  clock; every register samples on the rising edge.
REQ-003: rst_n_i  input  1  asynchronous active-low reset.
REQ-004: ex_valid_i  input  1  resolved instruction offered by EXU.
REQ-005: ex_ready_o  output  1  bju accepts the offered instruction.
REQ-006: ex_pc_i, ex_pred_pc_i, ex_imm_i, ex_src1_i, ex_csr_data_i  input  32 each  PC, fetch-predicted next PC, immediate, rs1 value, CSR target (mtvec/mepc).
REQ-007: ex_opinfo_i  input  12  one-hot opcode class in the shared opinfo bit order (bit0 alu ... bit11 sys).
REQ-008: ex_cnd_i, ex_ecall_i, ex_mret_i, ex_epoch_i  input  1 each  branch taken, ecall, mret, fetch epoch tag.
REQ-009: redir_valid_o  output  1  redirect request to IFU; redir_ready_i  input  1  IFU accepts it.
REQ-010: redir_pc_o  output  32  corrected fetch PC.
REQ-011: flush_o  output  1  one-cycle wrong-path squash pulse; epoch_o  output  1  current architectural epoch.
REQ-012: perf_cf_cnt_o, perf_mis_cnt_o  output  CNT_W each  control-flow and mispredict counts (present only under the configuration macro).

Function
REQ-013: Actual next PC SHALL be: pc+imm for a taken branch or jal; (src1+imm) with bit0 cleared for jalr; csr_data for ecall or mret; pc+4 otherwise; all sums modulo 2^32.
REQ-014: Mispredict SHALL be declared when actual next PC != ex_pred_pc_i.
REQ-015: An instruction SHALL be accepted when ex_valid_i && ex_ready_o are high in the same cycle.
REQ-016: An accepted instruction with ex_epoch_i != epoch_o SHALL be discarded with no redirect, no flush and no counter update.
REQ-017: FSM states IDLE and WAIT_ACK; in IDLE ex_ready_o = 1; in WAIT_ACK ex_ready_o = 0.
REQ-018: An accepted, epoch-matching mispredict SHALL, on the next edge, set redir_valid_o = 1, load redir_pc_o, pulse flush_o for exactly one cycle, toggle epoch_o, and enter WAIT_ACK.
REQ-019: In WAIT_ACK, redir_valid_o and redir_pc_o SHALL hold stable until redir_ready_i = 1; on that edge the FSM returns to IDLE and redir_valid_o falls.
REQ-020: A correct prediction SHALL produce no output change besides the counters.
REQ-021: Redirect latency SHALL be exactly one cycle from acceptance.

Reset
REQ-022: With rst_n_i = 0, the FSM SHALL enter IDLE and redir_valid_o, redir_pc_o, flush_o, epoch_o and both counters SHALL be 0 immediately, regardless of clk_i.
REQ-023: Reset during WAIT_ACK SHALL drop the pending redirect without issuing a flush.

Configuration
REQ-024: With YSYX_23060251_BJU_PERF_EN defined, the counters SHALL increment (wrapping at 2^CNT_W) on each accepted, epoch-matching instruction whose opinfo marks a branch, jal, jalr or sys class (perf_cf_cnt_o), and additionally on each mispredict (perf_mis_cnt_o).
REQ-025: Without YSYX_23060251_BJU_PERF_EN, the counter ports and their logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-026: The shared package SHALL hold the FSM state enum, the npc-select enum and the opinfo bit-index constants.
REQ-027: Target computation SHALL be a combinational sub-module named bju_npc; the FSM, epoch and counters SHALL reside in bju.

Verification
REQ-028: Branch pc=0x80000000, imm=0x10, cnd=1, pred=0x80000010 -> no redirect, epoch_o stays 0, perf_cf_cnt_o=1.
REQ-029: Same branch with cnd=0 -> next cycle redir_valid_o=1, redir_pc_o=0x80000004, flush_o high for one cycle, epoch_o=1, perf_mis_cnt_o=1.
REQ-030: jalr pc=0x80000000, src1=0x80000101, imm=2, pred=0x80000004 -> redir_pc_o=0x80000102.
REQ-031: redir_ready_i low for 3 cycles -> valid and pc stable, ex_ready_o=0; then redir_ready_i=1 -> IDLE next cycle.
REQ-032: After an epoch toggle, a mispredicting instruction tagged with epoch 0 -> ignored, no counter change.
REQ-033: mret with csr=0x80000200 -> redirect to 0x80000200; rst_n_i asserted in WAIT_ACK -> all outputs 0 without waiting for a clock edge.
